// File: rtl/rock_fa_ctrl.sv
// rtl/rock_fa_ctrl.sv - rocking frequency/amplitude controller with timed ramp-down
// Holds saturating F/A registers; RUN accepts commands, RAMP steps both to zero, IDLE awaits start.
module rock_fa_ctrl #(
   parameter int W        = 4,
   parameter int F_INIT   = 5,
   parameter int A_INIT   = 5,
   parameter int F_MAX    = 2**W-1,
   parameter int A_MAX    = 2**W-1,
   parameter int RAMP_DIV = 8
) (
   input  logic         FclkDff,
   input  logic         reset,
   input  logic         f_up,
   input  logic         f_down,
   input  logic         a_up,
   input  logic         a_down,
   input  logic         stop,
   input  logic         start,
   output logic [W-1:0] F,
   output logic [W-1:0] A,
   output logic         F0,
   output logic         AF0,
   output logic         busy,
   output logic         sat
);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_RAMP = 2'd1;
   localparam logic [1:0] ST_IDLE = 2'd2;

   localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(RAMP_DIV - 1);
   localparam logic [W-1:0]  FMAX     = W'(F_MAX);
   localparam logic [W-1:0]  AMAX     = W'(A_MAX);
   localparam logic [W-1:0]  FINIT    = W'(F_INIT);
   localparam logic [W-1:0]  AINIT    = W'(A_INIT);

   generate
      if (F_INIT > F_MAX) begin : g_bad_f_init
         $error("rock_fa_ctrl: F_INIT exceeds F_MAX");
      end
      if (A_INIT > A_MAX) begin : g_bad_a_init
         $error("rock_fa_ctrl: A_INIT exceeds A_MAX");
      end
      if (RAMP_DIV < 1) begin : g_bad_ramp_div
         $error("rock_fa_ctrl: RAMP_DIV must be at least 1");
      end
   endgenerate

   logic [1:0]    state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [W-1:0]  f_n, a_n;
   logic          sat_n;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      f_n     = F;
      a_n     = A;
      sat_n   = 1'b0;
      case (state)
         ST_RUN: begin
            if (stop) begin
               cnt_n   = '0;
               state_n = (F == '0 && A == '0) ? ST_IDLE : ST_RAMP;
            end else begin
               // Opposing pulses in the same cycle cancel without flagging sat.
               if (f_up && !f_down) begin
                  if (F == FMAX) sat_n = 1'b1;
                  else           f_n   = F + 1'b1;
               end else if (f_down && !f_up) begin
                  if (F == '0) sat_n = 1'b1;
                  else         f_n   = F - 1'b1;
               end
               if (a_up && !a_down) begin
                  if (A == AMAX) sat_n = 1'b1;
                  else           a_n   = A + 1'b1;
               end else if (a_down && !a_up) begin
                  if (A == '0) sat_n = 1'b1;
                  else         a_n   = A - 1'b1;
               end
            end
         end
         ST_RAMP: begin
            if (cnt == CNT_LAST) begin
               cnt_n = '0;
               if (F != '0) f_n = F - 1'b1;
               if (A != '0) a_n = A - 1'b1;
               if (f_n == '0 && a_n == '0) state_n = ST_IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         ST_IDLE: begin
            f_n = '0;
            a_n = '0;
            if (start) begin
               f_n     = FINIT;
               a_n     = AINIT;
               state_n = ST_RUN;
            end
         end
         default: state_n = ST_RUN;
      endcase
   end

   always_ff @(posedge FclkDff or posedge reset) begin
      if (reset) begin
         state <= ST_RUN;
         cnt   <= '0;
         F     <= FINIT;
         A     <= AINIT;
         sat   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         F     <= f_n;
         A     <= a_n;
         sat   <= sat_n;
      end
   end

   assign F0   = (F == '0);
   assign AF0  = F0 && (A == '0);
   assign busy = (state == ST_RAMP);

endmodule

// File: tb/tb_rock_fa_ctrl.sv
// tb/tb_rock_fa_ctrl.sv - self-checking bench for rock_fa_ctrl against a behavioural model
module tb_rock_fa_ctrl;

   localparam int W  = 4;
   localparam int RD = 4;
   localparam int FM = 15;
   localparam int AM = 15;

   logic FclkDff = 1'b0;
   logic reset   = 1'b1;
   logic f_up = 0, f_down = 0, a_up = 0, a_down = 0, stop = 0, start = 0;
   logic [W-1:0] F, A;
   logic F0, AF0, busy, sat;

   int checks = 0;
   int errors = 0;

   // Model: ramp values are derived from the snapshot at stop and elapsed cycles.
   int mf, ma, mode, ramp_t, rf0, ra0, msat;

   rock_fa_ctrl #(.W(W), .RAMP_DIV(RD)) dut (
      .FclkDff(FclkDff), .reset(reset),
      .f_up(f_up), .f_down(f_down), .a_up(a_up), .a_down(a_down),
      .stop(stop), .start(start),
      .F(F), .A(A), .F0(F0), .AF0(AF0), .busy(busy), .sat(sat)
   );

   always #5 FclkDff = ~FclkDff;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mf = 5; ma = 5; mode = 0; msat = 0; ramp_t = 0;
   endtask

   task automatic model_edge();
      int k;
      msat = 0;
      if (mode == 0) begin
         if (stop) begin
            rf0 = mf; ra0 = ma; ramp_t = 0;
            mode = (mf == 0 && ma == 0) ? 2 : 1;
         end else begin
            if (f_up && !f_down)      begin if (mf == FM) msat = 1; else mf++; end
            else if (f_down && !f_up) begin if (mf == 0)  msat = 1; else mf--; end
            if (a_up && !a_down)      begin if (ma == AM) msat = 1; else ma++; end
            else if (a_down && !a_up) begin if (ma == 0)  msat = 1; else ma--; end
         end
      end else if (mode == 1) begin
         ramp_t++;
         k  = ramp_t / RD;
         mf = (rf0 > k) ? rf0 - k : 0;
         ma = (ra0 > k) ? ra0 - k : 0;
         if (mf == 0 && ma == 0) mode = 2;
      end else begin
         mf = 0; ma = 0;
         if (start) begin mf = 5; ma = 5; mode = 0; end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".F"},    F,    mf);
      chk({tag, ".A"},    A,    ma);
      chk({tag, ".F0"},   F0,   (mf == 0));
      chk({tag, ".AF0"},  AF0,  (mf == 0 && ma == 0));
      chk({tag, ".busy"}, busy, (mode == 1));
      chk({tag, ".sat"},  sat,  msat);
   endtask

   task automatic step(input string tag, input logic fu, input logic fd, input logic au,
                       input logic ad, input logic st, input logic sr);
      @(negedge FclkDff);
      f_up = fu; f_down = fd; a_up = au; a_down = ad; stop = st; start = sr;
      @(posedge FclkDff);
      model_edge();
      #2;
      check_all(tag);
   endtask

   task automatic async_reset(input string tag);
      @(negedge FclkDff);
      f_up = 0; f_down = 0; a_up = 0; a_down = 0; stop = 0; start = 0;
      #1 reset = 1'b1;
      #1 model_reset();
      check_all(tag);
      #1 reset = 1'b0;
   endtask

   initial begin
      model_reset();
      #12;
      check_all("reset");
      chk("reset.F_const", F, 5);
      @(negedge FclkDff);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) step("f_up_x12", 1, 0, 0, 0, 0, 0);
      chk("f_up_x12.F_final", F, 15);
      step("idle1", 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) step("a_down_x6", 0, 0, 0, 1, 0, 0);
      chk("a_down_x6.A_final", A, 0);

      for (int i = 0; i < 8; i++) step("f_to_7", 0, 1, 0, 0, 0, 0);
      step("f_both", 1, 1, 0, 0, 0, 0);
      chk("f_both.F7", F, 7);
      chk("f_both.nosat", sat, 0);
      step("a_down_at0", 0, 0, 0, 1, 0, 0);
      chk("a_down_at0.sat", sat, 1);
      for (int i = 0; i < 15; i++) step("a_to_15", 0, 0, 1, 0, 0, 0);
      step("a_up_at15", 0, 0, 1, 0, 0, 0);
      chk("a_up_at15.sat", sat, 1);
      chk("a_up_at15.A", A, 15);

      for (int i = 0; i < 2; i++)  step("f_to_5", 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) step("a_to_3", 0, 0, 0, 1, 0, 0);
      step("ramp_e0", 0, 0, 0, 0, 1, 0);
      chk("ramp_e0.busy", busy, 1);
      for (int i = 1; i <= 20; i++) begin
         step("ramp", (i % 3) == 0, 0, 0, 0, 0, 0);
         if (i == 4)  begin chk("ramp4.F", F, 4); chk("ramp4.A", A, 2); end
         if (i == 16) begin chk("ramp16.F", F, 1); chk("ramp16.A", A, 0); end
      end
      chk("ramp_end.AF0", AF0, 1);
      chk("ramp_end.busy", busy, 0);

      step("idle_cmd", 1, 0, 0, 0, 1, 0);
      chk("idle_cmd.F", F, 0);
      step("restart", 0, 0, 0, 0, 0, 1);
      chk("restart.F", F, 5);
      step("stop2", 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) step("ramp2", 0, 0, 0, 0, 0, 0);
      async_reset("mid_ramp_reset");
      chk("mid_ramp_reset.busy", busy, 0);

      for (int i = 0; i < 5; i++) step("zero_fa", 0, 1, 0, 1, 0, 0);
      step("stop_zero", 0, 0, 0, 0, 1, 0);
      chk("stop_zero.busy", busy, 0);
      step("stop_zero_idle", 1, 0, 1, 0, 0, 0);
      chk("stop_zero_idle.F", F, 0);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 149) == 0) async_reset("rand_reset");
         else step("rand", $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rock_fa_ctrl.md
# rock_fa_ctrl

Parametrised frequency/amplitude controller for the cradle rocking drive. It holds the rocking frequency F and amplitude A as saturating registers, adjusted by single-cycle up/down command pulses. It adds a timed ramp-down mode that brings both values to zero, and an idle state that waits for a restart. It sits between the sensor/command decoder and the motor pattern generator, which consumes F, A, F0 and AF0.

## Interface
- W, 4: width of F and A.
- F_INIT, 5: F value after reset and after restart.
- A_INIT, 5: A value after reset and after restart.
- F_MAX, 2**W-1: upper saturation limit of F.
- A_MAX, 2**W-1: upper saturation limit of A.
- RAMP_DIV, 8: clock cycles between ramp-down steps; must be ≥1.

Ports (clock and reset first):
- FclkDff  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- f_up  in  1  single-cycle pulse: F+1.
- f_down  in  1  single-cycle pulse: F-1.
- a_up  in  1  single-cycle pulse: A+1.
- a_down  in  1  single-cycle pulse: A-1.
- stop  in  1  single-cycle pulse: start ramp-down.
- start  in  1  single-cycle pulse: leave IDLE and reload initial values.
- F  out  W  current frequency, registered.
- A  out  W  current amplitude, registered.
- F0  out  1  F == 0, combinational from register.
- AF0  out  1  F == 0 and A == 0.
- busy  out  1  high while in RAMP.
- sat  out  1  one-cycle pulse: an up/down command was dropped at a limit.

## Operation
- States are RUN, RAMP and IDLE.
- **Reset:**
  - State is RUN, F=F_INIT, A=A_INIT.
  - Ramp counter is 0; busy=0, sat=0.
  - F0 and AF0 follow from the reset values.
- **RUN:**
  - f_up and f_down are evaluated independently of a_up and a_down.
  - If f_up and f_down arrive in the same cycle, F is unchanged and sat is not raised. The same rule applies to the A pair.
  - f_up with F==F_MAX, or f_down with F==0: F is unchanged and sat=1 for one cycle. The same rule applies to A with A_MAX and 0.
  - All arithmetic is W-bit with saturation; there is never wrap-around.
  - stop: the next state is RAMP and the ramp counter is cleared. Any up/down commands in the same cycle are discarded, with no sat.
  - If F==0 and A==0 when stop arrives, the next state is IDLE directly.
  - start is ignored in RUN.
- **RAMP:**
  - The ramp counter counts 0..RAMP_DIV-1.
  - On the edge where it wraps, one step occurs: A decrements if A>0 and F decrements if F>0, in the same step.
  - If that step leaves F==0 and A==0, the state becomes IDLE on that same edge.
  - All commands, start and stop are ignored; sat stays 0.
- **IDLE:**
  - F and A are held at 0.
  - up/down commands and stop are ignored.
  - start: F=F_INIT, A=A_INIT, state RUN, on the next edge.
- F_INIT must be ≤ F_MAX and A_INIT must be ≤ A_MAX; the implementation checks this at elaboration time.
- The ramp counter width is clog2(RAMP_DIV), minimum 1.

## Timing
- A command sampled at edge n is visible on F/A after edge n. F0 and AF0 settle in the same cycle as F/A.
- sat is registered: it is high for exactly the cycle after the dropped command's edge.
- Ramp timing:
  - stop is sampled at edge e0; busy=1 from e0.
  - Step k occurs at edge e0 + k·RAMP_DIV.
  - Total ramp time is max(F,A)·RAMP_DIV cycles.
  - busy falls on the edge of the final step.
- With RAMP_DIV=1, a step occurs every cycle.
- Reset asserted in any state, including mid-ramp, immediately forces the reset values. The ramp is abandoned.
- Release of reset is synchronous to the next FclkDff edge.

## Test plan
- Reset with defaults (W=4): F=5, A=5, F0=0, AF0=0, busy=0, sat=0. Pulse reset mid-operation → same values, asynchronously.
- f_up ×12 from F=5 → F=15 after 10 pulses; the last 2 pulses each give a one-cycle sat and F stays 15. a_down ×6 from A=5 → A=0, one sat.
- f_up and f_down in the same cycle with F=7 → F=7, sat=0. a_up at A=15 and a_down at A=0 (separate tests) → A unchanged, sat=1.
- RAMP_DIV=4, F=5, A=3, stop at e0:
  - busy=1.
  - (F,A) = (4,2) at e0+4, (3,1) at +8, (2,0) at +12, (1,0) at +16.
  - (0,0) at +20, where AF0=1, busy=0 and the state is IDLE.
  - f_up during the ramp → no effect.
- In IDLE: f_up and stop → F=A=0. start → F=5, A=5, RUN, next edge. Then stop with reset asserted at e0+6 → F=5, A=5, busy=0.
- F=0 and A=0 via a_down/f_down, then stop → IDLE next edge, busy never asserted.
